// File: rtl/ram_bank_if.sv
// Request/ack bus of the RAM bank: request fields driven by the master, status and read data by the bank.
interface ram_bank_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    logic                  req_i;
    logic                  we_i;
    logic [ADDR_W-1:0]     addr_i;
    logic [DATA_W/8-1:0]   be_i;
    logic [DATA_W-1:0]     data_i;
    logic                  busy_o;
    logic                  ack_o;
    logic [DATA_W-1:0]     data_o;
    logic                  err_o;

    modport master (
        output req_i, we_i, addr_i, be_i, data_i,
        input  busy_o, ack_o, data_o, err_o
    );

    modport slave (
        input  req_i, we_i, addr_i, be_i, data_i,
        output busy_o, ack_o, data_o, err_o
    );
endinterface

// File: rtl/ram_bank.sv
// Single-port byte-enabled SRAM bank with req/ack handshake and out-of-range detection.
// Latency: ack 1 cycle after acceptance (writes, RD_LAT=1 reads) or 2 cycles (RD_LAT=2 reads).
// Backpressure: busy_o is high from acceptance through the ack cycle; req_i is ignored meanwhile.
module ram_bank #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4096,
    parameter int ADDR_W = 32,
    parameter int RD_LAT = 1
) (
    input  logic         clk,
    input  logic         rst,
    ram_bank_if.slave    bus
);

    localparam int NB    = DATA_W / 8;
    localparam int OFF   = $clog2(NB);
    localparam int IDX   = $clog2(DEPTH);
    localparam int IDX_W = (IDX > 0) ? IDX : 1;
    localparam int HI    = OFF + IDX;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ACK  = 2'd2
    } state_t;

    state_t              state_q;
    state_t              state_d;
    logic [DATA_W-1:0]   mem [DEPTH];
    logic [IDX_W-1:0]    idx;
    logic                oor;
    logic                accept;
    logic [DATA_W-1:0]   rd_word;
    logic [DATA_W-1:0]   rd_buf;
    logic [DATA_W-1:0]   data_q;
    logic                err_q;
    logic                unused_addr;

    // Byte-offset bits only select within a word and are deliberately dropped.
    assign idx         = IDX_W'(bus.addr_i >> OFF);
    assign oor         = (bus.addr_i >> HI) != '0;
    assign unused_addr = ^bus.addr_i;
    assign accept      = (state_q == IDLE) && bus.req_i;
    assign rd_word     = oor ? '0 : mem[idx];

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (bus.req_i) begin
                    state_d = (!bus.we_i && RD_LAT == 2) ? WAIT : ACK;
                end
            end
            WAIT:    state_d = ACK;
            ACK:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            err_q   <= 1'b0;
            rd_buf  <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                err_q <= oor;
                if (!bus.we_i) begin
                    rd_buf <= rd_word;
                    if (RD_LAT == 1) begin
                        data_q <= rd_word;
                    end
                end
            end
            // Two-cycle reads publish the word sampled at acceptance as WAIT hands over to ACK.
            if (state_q == WAIT) begin
                data_q <= rd_buf;
            end
        end
    end

    // Contents survive reset; only a request accepted outside reset may write.
    always_ff @(posedge clk) begin
        if (!rst && accept && bus.we_i && !oor) begin
            for (int b = 0; b < NB; b++) begin
                if (bus.be_i[b]) begin
                    mem[idx][8*b +: 8] <= bus.data_i[8*b +: 8];
                end
            end
        end
    end

    assign bus.busy_o = (state_q != IDLE);
    assign bus.ack_o  = (state_q == ACK);
    assign bus.err_o  = (state_q == ACK) && err_q;
    assign bus.data_o = data_q;

endmodule

// File: tb/tb_ram_bank.sv
// Bench for ram_bank: RD_LAT=1 and RD_LAT=2 instances checked against an array reference model.
module tb_ram_bank;

    logic clk;
    logic rst;
    int   n_cmp = 0;
    int   n_bad = 0;

    logic [31:0] ref_mem [2][1024];
    logic [31:0] last_rd [2];

    ram_bank_if #(.DATA_W(32), .ADDR_W(32)) b1 ();
    ram_bank_if #(.DATA_W(32), .ADDR_W(32)) b2 ();

    ram_bank #(.DATA_W(32), .DEPTH(1024), .ADDR_W(32), .RD_LAT(1)) u_dut1 (
        .clk (clk),
        .rst (rst),
        .bus (b1.slave)
    );

    ram_bank #(.DATA_W(32), .DEPTH(1024), .ADDR_W(32), .RD_LAT(2)) u_dut2 (
        .clk (clk),
        .rst (rst),
        .bus (b2.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got running want finished");
        $fatal(1);
    end

    // Reference model: 4-byte words, 1024 of them, anything at or above byte 4096 is out of range.
    function automatic bit m_oor(input logic [31:0] a);
        return a >= 32'h1000;
    endfunction

    function automatic int m_idx(input logic [31:0] a);
        return int'((a / 4) % 1024);
    endfunction

    function automatic logic [31:0] m_read(input int sel, input logic [31:0] a);
        return m_oor(a) ? 32'h0 : ref_mem[sel][m_idx(a)];
    endfunction

    task automatic m_write(input int sel, input logic [31:0] a, input logic [3:0] be,
                           input logic [31:0] d);
        int i;
        i = m_idx(a);
        if (!m_oor(a)) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) ref_mem[sel][i][8*b +: 8] = d[8*b +: 8];
            end
        end
    endtask

    function automatic logic obs_busy(input int sel);
        return (sel == 0) ? b1.busy_o : b2.busy_o;
    endfunction

    function automatic logic obs_ack(input int sel);
        return (sel == 0) ? b1.ack_o : b2.ack_o;
    endfunction

    function automatic logic obs_err(input int sel);
        return (sel == 0) ? b1.err_o : b2.err_o;
    endfunction

    function automatic logic [31:0] obs_data(input int sel);
        return (sel == 0) ? b1.data_o : b2.data_o;
    endfunction

    task automatic drive(input int sel, input logic req, input logic we, input logic [31:0] a,
                         input logic [3:0] be, input logic [31:0] d);
        if (sel == 0) begin
            b1.req_i = req; b1.we_i = we; b1.addr_i = a; b1.be_i = be; b1.data_i = d;
        end else begin
            b2.req_i = req; b2.we_i = we; b2.addr_i = a; b2.be_i = be; b2.data_i = d;
        end
    endtask

    // One request from an idle bank; lat counts cycles from acceptance to the ack (99 when no ack arrives).
    task automatic op(input int sel, input logic we, input logic [31:0] a, input logic [3:0] be,
                      input logic [31:0] d, output int lat, output int busy_n,
                      output logic err, output logic [31:0] rd);
        @(negedge clk);
        drive(sel, 1'b1, we, a, be, d);
        @(negedge clk);
        drive(sel, 1'b0, 1'($urandom), $urandom, 4'($urandom), $urandom);
        lat = 99; busy_n = 0; err = 1'bx; rd = 'x;
        for (int c = 1; c <= 8; c++) begin
            if (obs_busy(sel)) busy_n++;
            if (obs_ack(sel)) begin
                lat = c; err = obs_err(sel); rd = obs_data(sel);
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        drive(0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        drive(1, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        repeat (3) @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            n_cmp++; if (obs_busy(s) !== 1'b0) begin n_bad++; $display("FAIL reset_busy dut%0d got %b want 0", s, obs_busy(s)); end
            n_cmp++; if (obs_ack(s) !== 1'b0) begin n_bad++; $display("FAIL reset_ack dut%0d got %b want 0", s, obs_ack(s)); end
            n_cmp++; if (obs_err(s) !== 1'b0) begin n_bad++; $display("FAIL reset_err dut%0d got %b want 0", s, obs_err(s)); end
            n_cmp++; if (obs_data(s) !== 32'h0) begin n_bad++; $display("FAIL reset_data dut%0d got %h want 0", s, obs_data(s)); end
            last_rd[s] = 32'h0;
        end
        rst = 1'b0;
    endtask

    task automatic test_init;
        int lat, bn; logic err; logic [31:0] rd, d;
        for (int s = 0; s < 2; s++) begin
            for (int i = 0; i < 1024; i++) begin
                d = $urandom;
                op(s, 1'b1, 32'(i * 4), 4'hF, d, lat, bn, err, rd);
                m_write(s, 32'(i * 4), 4'hF, d);
            end
        end
    endtask

    task automatic test_directed;
        int lat, bn; logic err; logic [31:0] rd;
        op(0, 1'b1, 32'h10, 4'hF, 32'hDEADBEEF, lat, bn, err, rd);
        m_write(0, 32'h10, 4'hF, 32'hDEADBEEF);
        n_cmp++; if (lat !== 1) begin n_bad++; $display("FAIL wr_lat got %0d want 1", lat); end
        n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL wr_err got %b want 0", err); end
        op(0, 1'b0, 32'h10, 4'h0, 32'h0, lat, bn, err, rd);
        n_cmp++; if (lat !== 1) begin n_bad++; $display("FAIL rd_lat got %0d want 1", lat); end
        n_cmp++; if (rd !== 32'hDEADBEEF) begin n_bad++; $display("FAIL rd_full got %h want deadbeef", rd); end
        n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL rd_err got %b want 0", err); end
        op(0, 1'b1, 32'h10, 4'h4, 32'h00AA0000, lat, bn, err, rd);
        m_write(0, 32'h10, 4'h4, 32'h00AA0000);
        op(0, 1'b1, 32'h11, 4'h0, 32'hFFFFFFFF, lat, bn, err, rd);
        n_cmp++; if (lat !== 1 || err !== 1'b0) begin n_bad++; $display("FAIL be0_ack got lat %0d err %b want 1 0", lat, err); end
        op(0, 1'b0, 32'h13, 4'h0, 32'h0, lat, bn, err, rd);
        n_cmp++; if (rd !== 32'hDEAABEEF) begin n_bad++; $display("FAIL rd_partial got %h want deaabeef", rd); end
        last_rd[0] = rd;
    endtask

    task automatic test_rdlat2;
        int lat, bn; logic err; logic [31:0] rd;
        op(1, 1'b1, 32'h10, 4'hF, 32'hDEADBEEF, lat, bn, err, rd);
        n_cmp++; if (lat !== 1) begin n_bad++; $display("FAIL l2_wr_lat got %0d want 1", lat); end
        op(1, 1'b1, 32'h10, 4'h4, 32'h00AA0000, lat, bn, err, rd);
        m_write(1, 32'h10, 4'hF, 32'hDEADBEEF);
        m_write(1, 32'h10, 4'h4, 32'h00AA0000);
        op(1, 1'b0, 32'h10, 4'h0, 32'h0, lat, bn, err, rd);
        n_cmp++; if (lat !== 2) begin n_bad++; $display("FAIL l2_rd_lat got %0d want 2", lat); end
        n_cmp++; if (bn !== 2) begin n_bad++; $display("FAIL l2_busy_cycles got %0d want 2", bn); end
        n_cmp++; if (rd !== 32'hDEAABEEF) begin n_bad++; $display("FAIL l2_rd_data got %h want deaabeef", rd); end
        n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL l2_rd_err got %b want 0", err); end
        last_rd[1] = rd;
    endtask

    task automatic test_oor;
        int lat, bn; logic err; logic [31:0] rd;
        for (int s = 0; s < 2; s++) begin
            op(s, 1'b1, 32'h1000, 4'hF, 32'h12345678, lat, bn, err, rd);
            n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL oor_wr_err dut%0d got %b want 1", s, err); end
            op(s, 1'b0, 32'h1000, 4'h0, 32'h0, lat, bn, err, rd);
            n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL oor_rd_err dut%0d got %b want 1", s, err); end
            n_cmp++; if (rd !== 32'h0) begin n_bad++; $display("FAIL oor_rd_data dut%0d got %h want 0", s, rd); end
            op(s, 1'b0, 32'h0, 4'h0, 32'h0, lat, bn, err, rd);
            n_cmp++; if (rd !== m_read(s, 32'h0) || err !== 1'b0) begin
                n_bad++; $display("FAIL oor_alias dut%0d got %h/%b want %h/0", s, rd, err, m_read(s, 32'h0));
            end
            last_rd[s] = rd;
        end
    endtask

    // req_i held high: accepts must land on every other cycle only, each ack one cycle wide.
    task automatic test_back_to_back;
        logic [31:0] pend;
        logic        want;
        pend = 32'h10;
        @(negedge clk);
        for (int k = 0; k < 20; k++) begin
            want = 1'(k % 2);
            n_cmp++; if (obs_busy(0) !== want) begin n_bad++; $display("FAIL b2b_busy cyc %0d got %b want %b", k, obs_busy(0), want); end
            n_cmp++; if (obs_ack(0) !== want) begin n_bad++; $display("FAIL b2b_ack cyc %0d got %b want %b", k, obs_ack(0), want); end
            if (want) begin
                n_cmp++; if (obs_data(0) !== m_read(0, pend)) begin
                    n_bad++; $display("FAIL b2b_data cyc %0d got %h want %h", k, obs_data(0), m_read(0, pend));
                end
                drive(0, 1'b1, 1'($urandom), $urandom, 4'($urandom), $urandom);
            end else begin
                pend = ((k / 2) % 2 == 1) ? 32'h14 : 32'h10;
                drive(0, 1'b1, 1'b0, pend, 4'h0, 32'h0);
            end
            @(negedge clk);
        end
        drive(0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        last_rd[0] = m_read(0, pend);
    endtask

    task automatic test_rst_midflight;
        int lat, bn; logic err; logic [31:0] rd;
        @(negedge clk);
        drive(1, 1'b1, 1'b0, 32'h10, 4'h0, 32'h0);
        @(negedge clk);
        drive(1, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        n_cmp++; if (obs_busy(1) !== 1'b1 || obs_ack(1) !== 1'b0) begin
            n_bad++; $display("FAIL mid_wait got busy %b ack %b want 1 0", obs_busy(1), obs_ack(1));
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_cmp++; if (obs_ack(1) !== 1'b0) begin n_bad++; $display("FAIL mid_rst_ack got %b want 0", obs_ack(1)); end
        n_cmp++; if (obs_busy(1) !== 1'b0) begin n_bad++; $display("FAIL mid_rst_busy got %b want 0", obs_busy(1)); end
        n_cmp++; if (obs_data(1) !== 32'h0) begin n_bad++; $display("FAIL mid_rst_data got %h want 0", obs_data(1)); end
        last_rd[0] = 32'h0; last_rd[1] = 32'h0;
        op(1, 1'b0, 32'h10, 4'h0, 32'h0, lat, bn, err, rd);
        n_cmp++; if (lat !== 2 || rd !== 32'hDEAABEEF) begin
            n_bad++; $display("FAIL mid_after_rd got lat %0d data %h want 2 deaabeef", lat, rd);
        end
        last_rd[1] = rd;
        // A write interrupted in its ack cycle is already in the array.
        @(negedge clk);
        drive(1, 1'b1, 1'b1, 32'h18, 4'hF, 32'hC0FFEE11);
        @(negedge clk);
        drive(1, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        rst = 1'b1;
        m_write(1, 32'h18, 4'hF, 32'hC0FFEE11);
        @(negedge clk);
        rst = 1'b0;
        last_rd[0] = 32'h0; last_rd[1] = 32'h0;
        n_cmp++; if (obs_busy(1) !== 1'b0) begin n_bad++; $display("FAIL wr_rst_busy got %b want 0", obs_busy(1)); end
        op(1, 1'b0, 32'h18, 4'h0, 32'h0, lat, bn, err, rd);
        n_cmp++; if (rd !== 32'hC0FFEE11) begin n_bad++; $display("FAIL wr_rst_keep got %h want c0ffee11", rd); end
        last_rd[1] = rd;
    endtask

    task automatic test_rst_with_req;
        int lat, bn; logic err; logic [31:0] rd;
        @(negedge clk);
        rst = 1'b1;
        drive(0, 1'b1, 1'b1, 32'h20, 4'hF, ~m_read(0, 32'h20));
        @(negedge clk);
        rst = 1'b0;
        drive(0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        n_cmp++; if (obs_busy(0) !== 1'b0) begin n_bad++; $display("FAIL rstreq_busy got %b want 0", obs_busy(0)); end
        n_cmp++; if (obs_data(0) !== 32'h0) begin n_bad++; $display("FAIL rstreq_data got %h want 0", obs_data(0)); end
        last_rd[0] = 32'h0; last_rd[1] = 32'h0;
        op(0, 1'b0, 32'h20, 4'h0, 32'h0, lat, bn, err, rd);
        n_cmp++; if (rd !== m_read(0, 32'h20)) begin n_bad++; $display("FAIL rstreq_nowrite got %h want %h", rd, m_read(0, 32'h20)); end
        last_rd[0] = rd;
    endtask

    task automatic test_random;
        int lat, bn, sel, exp_lat; logic err, we; logic [31:0] rd, a, d, exp_rd; logic [3:0] be;
        for (int n = 0; n < 300; n++) begin
            sel = $urandom_range(0, 1);
            we  = 1'($urandom);
            a   = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 4095));
            be  = 4'($urandom);
            d   = $urandom;
            op(sel, we, a, be, d, lat, bn, err, rd);
            exp_lat = (we || sel == 0) ? 1 : 2;
            n_cmp++; if (lat !== exp_lat) begin n_bad++; $display("FAIL rnd_lat #%0d got %0d want %0d", n, lat, exp_lat); end
            n_cmp++; if (bn !== exp_lat) begin n_bad++; $display("FAIL rnd_busy #%0d got %0d want %0d", n, bn, exp_lat); end
            n_cmp++; if (err !== m_oor(a)) begin n_bad++; $display("FAIL rnd_err #%0d addr %h got %b want %b", n, a, err, m_oor(a)); end
            if (we) begin
                n_cmp++; if (rd !== last_rd[sel]) begin n_bad++; $display("FAIL rnd_hold #%0d got %h want %h", n, rd, last_rd[sel]); end
                m_write(sel, a, be, d);
            end else begin
                exp_rd = m_read(sel, a);
                n_cmp++; if (rd !== exp_rd) begin n_bad++; $display("FAIL rnd_rd #%0d addr %h got %h want %h", n, a, rd, exp_rd); end
                last_rd[sel] = exp_rd;
            end
        end
    endtask

    initial begin
        test_reset();
        test_init();
        test_directed();
        test_rdlat2();
        test_oor();
        test_back_to_back();
        test_rst_midflight();
        test_rst_with_req();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ram_bank.md
RAM_BANK -- requirements
Module: ram_bank

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32: data width in bits; a multiple of 8, range 8..64.
REQ-002 The block SHALL have parameter DEPTH, default 4096: number of words; a power of two.
REQ-003 The block SHALL have parameter ADDR_W, default 32: byte address width.
REQ-004 The block SHALL have parameter RD_LAT, default 1: read latency in cycles from acceptance to ack; legal values 1 or 2.
REQ-005 The block SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-006 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-007 The block SHALL have port req_i, input, 1 bit: request valid.
REQ-008 The block SHALL have port we_i, input, 1 bit: 1 = write, 0 = read; qualified by req_i.
REQ-009 The block SHALL have port addr_i, input, ADDR_W bits: byte address.
REQ-010 The block SHALL have port be_i, input, DATA_W/8 bits: write byte enables; bit n enables data_i[8n+7:8n].
REQ-011 The block SHALL have port data_i, input, DATA_W bits: write data.
REQ-012 The block SHALL have port busy_o, output, 1 bit: high while a request is in flight; requests are not accepted while it is high.
REQ-013 The block SHALL have port ack_o, output, 1 bit: one-cycle completion pulse.
REQ-014 The block SHALL have port data_o, output, DATA_W bits: read data; valid when ack_o is high for a read.
REQ-015 The block SHALL have port err_o, output, 1 bit: out-of-range flag; valid only with ack_o.

Function
REQ-016 The word index SHALL be addr_i[OFF+IDX-1:OFF], where OFF = log2(DATA_W/8) and IDX = log2(DEPTH); the byte-offset bits SHALL be ignored.
REQ-017 A request SHALL be out of range when any addr_i bit at or above OFF+IDX is 1.
REQ-018 The FSM SHALL have three states: IDLE, WAIT and ACK. busy_o SHALL be 0 only in IDLE.
REQ-019 In IDLE with req_i=1, the request SHALL be accepted. A write, or a read with RD_LAT=1, SHALL go to ACK. A read with RD_LAT=2 SHALL go to WAIT.
REQ-020 WAIT SHALL go to ACK after exactly one cycle. ACK SHALL go to IDLE after exactly one cycle.
REQ-021 ack_o SHALL be 1 exactly during the ACK state. Maximum throughput is therefore one request per 2 cycles (RD_LAT=1) or 3 cycles (RD_LAT=2 read).
REQ-022 An in-range write SHALL update only the enabled bytes of the addressed word, at the acceptance clock edge.
REQ-023 A write with be_i=0 SHALL be acked with no memory change.
REQ-024 A read SHALL sample the array at the acceptance edge. data_o SHALL present that word in the ACK cycle.
REQ-025 data_o SHALL change only on read acks and SHALL otherwise hold its last value.
REQ-026 An out-of-range request SHALL be acked with err_o=1. It SHALL NOT modify memory. If it is a read, data_o SHALL be 0.
REQ-027 err_o SHALL be 0 on every in-range ack.
REQ-028 Inputs sampled outside acceptance SHALL be ignored. Deasserting req_i after acceptance SHALL NOT cancel the request.
REQ-029 A read accepted after a write's ack cycle SHALL return the newly written data.

Reset
REQ-030 With rst=1 at a clock edge, the state SHALL become IDLE and ack_o, err_o, busy_o and data_o SHALL all be 0.
REQ-031 A request presented in the same cycle as rst=1 SHALL be ignored and SHALL perform no write.
REQ-032 rst asserted in WAIT or ACK SHALL drop the pending ack. A write already committed at acceptance SHALL remain in memory.
REQ-033 Memory contents SHALL NOT be cleared by reset.

Verification
(All scenarios use DATA_W=32, DEPTH=1024 unless stated.)
REQ-034 Write 0xDEADBEEF to 0x10 with be=0xF, then read 0x10 -> each ack_o occurs 1 cycle after acceptance; read data_o=0xDEADBEEF; err_o=0.
REQ-035 Write 0x00AA0000 to 0x10 with be=0x4, then read 0x10 -> data_o=0xDEAABEEF.
REQ-036 With RD_LAT=2, read 0x10 -> busy_o is high for 2 cycles; ack_o comes 2 cycles after acceptance with data_o=0xDEAABEEF.
REQ-037 Write 0x12345678 to 0x1000, then read 0x1000 -> both acks have err_o=1; read data_o=0; a subsequent read of 0x0 is unchanged.
REQ-038 Hold req_i=1 continuously with reads of 0x10 and 0x14 alternating -> acceptances occur every 2nd cycle; no double accept; ack_o pulses exactly one cycle each.
REQ-039 Assert rst in the cycle after a read is accepted -> no ack_o; busy_o=0 next cycle; the next read of 0x10 completes normally.
